// File: rtl/row_window_sum.sv
// Vertical window sum over WIN_ROWS adjacent rows of a row-major sample stream.
// Two-stage pipeline: line-buffer read/register, then a registered column sum.
module row_window_sum #(
    parameter int unsigned  DATA_W   = 8,
    parameter int unsigned  COL_NUM  = 50,
    parameter int unsigned  ROW_NUM  = 50,
    parameter int unsigned  WIN_ROWS = 3,
    localparam int unsigned SUM_W    = DATA_W + $clog2(WIN_ROWS)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] pi_data,
    input  logic              pi_flag,
    output logic [SUM_W-1:0]  po_sum,
    output logic              po_flag,
    output logic              po_frame_end
);

    localparam int unsigned COL_W = $clog2(COL_NUM);
    localparam int unsigned ROW_W = $clog2(ROW_NUM);
    localparam int          NBUF  = int'(WIN_ROWS) - 1;

    logic [COL_W-1:0]  col_cnt_q, col_cnt_d;
    logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;
    logic              col_last, row_last;

    // line_q[k] holds the row k+1 above the current one, indexed by column.
    logic [DATA_W-1:0] line_q [NBUF][COL_NUM];

    logic [DATA_W-1:0] win_d [WIN_ROWS];
    logic [DATA_W-1:0] win_q [WIN_ROWS];
    logic              s1_flag_d, s1_flag_q;
    logic              s1_end_d, s1_end_q;

    logic [SUM_W-1:0]  sum_d, po_sum_q;
    logic              po_flag_q, po_end_q;

    assign col_last = (col_cnt_q == COL_W'(COL_NUM - 1));
    assign row_last = (row_cnt_q == ROW_W'(ROW_NUM - 1));

    always_comb begin
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        if (pi_flag) begin
            if (col_last) begin
                col_cnt_d = '0;
                row_cnt_d = row_last ? '0 : row_cnt_q + ROW_W'(1);
            end else begin
                col_cnt_d = col_cnt_q + COL_W'(1);
            end
        end
    end

    always_comb begin
        win_d[0] = pi_data;
        for (int k = 0; k < NBUF; k++) begin
            win_d[k+1] = line_q[k][col_cnt_q];
        end
        // Rows 0..WIN_ROWS-2 only refill the buffers, so prior-frame data never reaches a sum.
        s1_flag_d = pi_flag && (row_cnt_q >= ROW_W'(WIN_ROWS - 1));
        s1_end_d  = pi_flag && row_last && col_last;
    end

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < int'(WIN_ROWS); k++) begin
            sum_d = sum_d + SUM_W'(win_q[k]);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (pi_flag) begin
            line_q[0][col_cnt_q] <= pi_data;
            for (int k = 1; k < NBUF; k++) begin
                line_q[k][col_cnt_q] <= line_q[k-1][col_cnt_q];
            end
            win_q <= win_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            s1_flag_q <= 1'b0;
            s1_end_q  <= 1'b0;
            po_flag_q <= 1'b0;
            po_end_q  <= 1'b0;
            po_sum_q  <= '0;
        end else begin
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
            s1_flag_q <= s1_flag_d;
            s1_end_q  <= s1_end_d;
            po_flag_q <= s1_flag_q;
            po_end_q  <= s1_end_q;
            if (s1_flag_q) begin
                po_sum_q <= sum_d;
            end
        end
    end

    assign po_sum       = po_sum_q;
    assign po_flag      = po_flag_q;
    assign po_frame_end = po_end_q;

endmodule

// File: tb/tb_row_window_sum.sv
// Randomized scoreboard bench for row_window_sum: two geometries share one stimulus stream,
// each checked against a frame-array reference model.
module tb_row_window_sum;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pi_data = '0;
    logic       pi_flag = 1'b0;
    logic [9:0] a_sum, b_sum;
    logic       a_flag, a_fe, b_flag, b_fe;

    always #5 clk = ~clk;

    row_window_sum #(.DATA_W(8), .COL_NUM(50), .ROW_NUM(50), .WIN_ROWS(3)) dut_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .pi_data(pi_data), .pi_flag(pi_flag),
        .po_sum(a_sum), .po_flag(a_flag), .po_frame_end(a_fe)
    );

    row_window_sum #(.DATA_W(8), .COL_NUM(4), .ROW_NUM(5), .WIN_ROWS(4)) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .pi_data(pi_data), .pi_flag(pi_flag),
        .po_sum(b_sum), .po_flag(b_flag), .po_frame_end(b_fe)
    );

    typedef struct {
        int     sum;
        bit     fe;
        longint cyc;
    } exp_t;

    exp_t   qa[$];
    exp_t   qb[$];
    int     log_b[$];
    int     n_cmp = 0;
    int     n_fail = 0;
    longint cyc = 0;

    int cols[2]   = '{50, 4};
    int rows_n[2] = '{50, 5};
    int wins[2]   = '{3, 4};
    int smp[2][50][50];
    int m_row[2] = '{0, 0};
    int m_col[2] = '{0, 0};
    int last_sum[2] = '{0, 0};
    int flag_cnt[2] = '{0, 0};
    int fe_cnt[2] = '{0, 0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(string name, longint act, longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: store the frame as a 2-D picture; a sample in row r >= W-1 yields the sum of
    // the W samples above and including it in the same column, due 2 cycles later.
    function automatic void model_issue(int d);
        for (int i = 0; i < 2; i++) begin
            int   r = m_row[i];
            int   c = m_col[i];
            exp_t e;
            smp[i][r][c] = d;
            if (r >= wins[i] - 1) begin
                e.sum = 0;
                for (int k = r - wins[i] + 1; k <= r; k++) e.sum += smp[i][k][c];
                e.fe  = (r == rows_n[i] - 1) && (c == cols[i] - 1);
                e.cyc = cyc + 2;
                if (i == 0) qa.push_back(e);
                else qb.push_back(e);
            end
            m_col[i] = c + 1;
            if (m_col[i] == cols[i]) begin
                m_col[i] = 0;
                m_row[i] = (r + 1 == rows_n[i]) ? 0 : r + 1;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(int d);
        pi_data = d[7:0];
        pi_flag = 1'b1;
        model_issue(d);
        tick();
        pi_flag = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            pi_data = 8'($urandom);
            tick();
        end
    endtask

    task automatic do_reset();
        pi_flag = 1'b0;
        rst_n   = 1'b0;
        tick();
        qa.delete();
        qb.delete();
        m_row = '{0, 0};
        m_col = '{0, 0};
        last_sum = '{0, 0};
        cmp("reset a.po_flag", longint'(a_flag), 0);
        cmp("reset a.po_frame_end", longint'(a_fe), 0);
        cmp("reset a.po_sum", longint'(a_sum), 0);
        cmp("reset b.po_flag", longint'(b_flag), 0);
        cmp("reset b.po_frame_end", longint'(b_fe), 0);
        cmp("reset b.po_sum", longint'(b_sum), 0);
        rst_n = 1'b1;
    endtask

    task automatic mon(int i, logic f, logic fe, logic [9:0] s);
        string p = (i == 0) ? "a" : "b";
        exp_t  e;
        if (f) begin
            flag_cnt[i]++;
            if (fe) fe_cnt[i]++;
            if ((i == 0 && qa.size() == 0) || (i == 1 && qb.size() == 0)) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s.unexpected_po_flag: actual po_sum %0d required no output (t=%0t)",
                         p, s, $time);
            end else begin
                if (i == 0) e = qa.pop_front();
                else e = qb.pop_front();
                cmp({p, ".po_sum"}, longint'(s), e.sum);
                cmp({p, ".po_frame_end"}, longint'(fe), longint'(e.fe));
                cmp({p, ".latency_cycle"}, cyc, e.cyc);
            end
            if (i == 1) log_b.push_back(int'(s));
            last_sum[i] = int'(s);
        end else begin
            cmp({p, ".frame_end_without_flag"}, longint'(fe), 0);
            cmp({p, ".po_sum_hold"}, longint'(s), last_sum[i]);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, a_flag, a_fe, a_sum);
            mon(1, b_flag, b_fe, b_sum);
        end
    end

    task automatic drain_check(string name);
        idle(4);
        cmp({name, ".a_pending"}, qa.size(), 0);
        cmp({name, ".b_pending"}, qb.size(), 0);
    endtask

    initial begin
        do_reset();

        // Small geometry directed frame: sample = 16*row + col.
        fe_cnt[1] = 0;
        log_b.delete();
        for (int n = 0; n < 20; n++) issue(16 * (n / 4) + (n % 4));
        drain_check("directed");
        cmp("b.output_count", log_b.size(), 8);
        if (log_b.size() >= 8) begin
            cmp("b.row3_col1", log_b[1], 100);
            cmp("b.row4_col3", log_b[7], 172);
        end
        cmp("b.frame_end_count", fe_cnt[1], 1);

        // Row-index frame cut by reset at row 10 col 7, then a complete row-index frame.
        do_reset();
        for (int n = 0; n <= 10 * 50 + 7; n++) begin
            issue(n / 50);
            idle(1);
        end
        do_reset();
        flag_cnt[0] = 0;
        fe_cnt[0]   = 0;
        for (int n = 0; n < 2500; n++) begin
            issue(n / 50);
            idle($urandom_range(0, 2));
        end
        drain_check("rowidx");
        cmp("a.frame_output_count", flag_cnt[0], 2400);
        cmp("a.frame_end_count", fe_cnt[0], 1);

        // Saturated data back-to-back, then a 200-frame followed directly by a 1-frame.
        flag_cnt[0] = 0;
        for (int n = 0; n < 2500; n++) issue(255);
        for (int n = 0; n < 2500; n++) issue(200);
        for (int n = 0; n < 2500; n++) issue(1);
        drain_check("flat");
        cmp("a.flat_output_count", flag_cnt[0], 3 * 2400);

        // Random data with random gaps and a long idle stretch of toggling data mid-row.
        for (int n = 0; n < 5000; n++) begin
            issue(int'($urandom_range(0, 255)));
            if (n == 2525) idle(100);
            else if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain_check("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/row_window_sum.md
ROW_WINDOW_SUM -- requirements
Module: row_window_sum

Interface
REQ-001 SHALL have parameter DATA_W, default 8, input sample width in bits.
REQ-002 SHALL have parameter COL_NUM, default 50, samples per row (range 2..1024).
REQ-003 SHALL have parameter ROW_NUM, default 50, rows per frame (range WIN_ROWS..1024).
REQ-004 SHALL have parameter WIN_ROWS, default 3, rows summed per output (range 2..8).
REQ-005 SHALL have derived localparam SUM_W = DATA_W + clog2(WIN_ROWS); default 10.
REQ-006 SHALL have port sys_clk  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port sys_rst_n  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port pi_data  input  DATA_W  input sample, row-major order.
REQ-009 SHALL have port pi_flag  input  1  one-cycle strobe; pi_data valid and accepted in that cycle.
REQ-010 SHALL have port po_sum  output  SUM_W  column sum of WIN_ROWS vertically adjacent samples.
REQ-011 SHALL have port po_flag  output  1  one-cycle strobe; po_sum valid in that cycle.
REQ-012 SHALL have port po_frame_end  output  1  one-cycle pulse coincident with last po_flag of a frame.

Function
REQ-013 SHALL maintain col_cnt (0..COL_NUM-1) and row_cnt (0..ROW_NUM-1), advancing only on pi_flag; col_cnt wraps to 0 and increments row_cnt; row_cnt wraps to 0 after col_cnt=COL_NUM-1 at row ROW_NUM-1 (new frame).
REQ-014 SHALL keep WIN_ROWS-1 line buffers, each COL_NUM x DATA_W, holding the previous WIN_ROWS-1 rows; on each pi_flag, buffer k's entry for col_cnt moves to buffer k+1, pi_data enters buffer 0, oldest is discarded.
REQ-015 SHALL accept pi_flag on consecutive cycles (one sample per clock) without loss; no minimum gap.
REQ-016 SHALL, for a sample at (row r, col c) with r >= WIN_ROWS-1, produce po_sum = sum of samples at col c of rows r-WIN_ROWS+1..r, zero-extended, no truncation or saturation.
REQ-017 SHALL produce no output for rows 0..WIN_ROWS-2 of every frame; exactly (ROW_NUM-WIN_ROWS+1)*COL_NUM po_flag pulses per frame.
REQ-018 SHALL assert po_flag exactly 2 cycles after the accepting pi_flag (stage 1: buffer read/register, stage 2: registered sum); fixed latency independent of gaps.
REQ-019 SHALL hold po_sum at its last value when po_flag is low.
REQ-020 SHALL pulse po_frame_end with the po_flag for (row ROW_NUM-1, col COL_NUM-1).
REQ-021 SHALL never combine rows across a frame boundary: after wrap, data from the prior frame is not used; rows 0..WIN_ROWS-2 of the new frame refill the buffers.
REQ-022 SHALL ignore pi_data when pi_flag is low; counters and buffers unchanged.

Reset
REQ-023 SHALL, while sys_rst_n=0 at a rising edge, set col_cnt=0, row_cnt=0, pipeline flags clear, po_flag=0, po_frame_end=0, po_sum=0.
REQ-024 SHALL not require line-buffer contents cleared; REQ-017/021 fill discipline makes stale contents unobservable.
REQ-025 SHALL, on reset mid-frame, discard in-flight results (no po_flag in the 2 cycles after reset release unless caused by new pi_flag) and treat the next accepted sample as (row 0, col 0).

Verification
REQ-026 Defaults, 50x50 frame, every sample = its row index, pi_flag every 52 cycles -> first po_flag at row 2 col 0 with po_sum=3 (0+1+2), 2 cycles after pi_flag; row 49 sums = 144; 2400 po_flag pulses; one po_frame_end.
REQ-027 Defaults, all samples 255, pi_flag asserted every cycle -> every po_sum=765, po_flag continuous from row 2 onward, no drops, count 2400.
REQ-028 Two back-to-back frames, frame 1 all 200, frame 2 all 1 -> frame 2 first output at its row 2 col 0 with po_sum=3; no output mixing 200s.
REQ-029 Reset asserted for 1 cycle after row 10 col 7 of a frame, then a fresh frame of row-index data -> no spurious po_flag; outputs identical to REQ-026.
REQ-030 WIN_ROWS=4, COL_NUM=4, ROW_NUM=5, DATA_W=8, sample = 16*row+col -> two output rows; (row 3, col 1) po_sum=100; (row 4, col 3) po_sum=172 with po_frame_end=1; SUM_W=10.
REQ-031 pi_data toggling randomly while pi_flag=0 for 100 cycles mid-row -> no po_flag, next outputs unaffected.
